// File: rtl/uart_tx_engine.sv
// 8N1 UART transmit engine: start bit, DATA_W data bits LSB-first, stop bit.
// Frame data and the baud divisor are latched at frame start, so later input
// changes do not affect a frame in flight. Every output is registered.
module uart_tx_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              tx_en,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  baud_div,
  output logic              tx_o,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               r_state, w_state_d;
  logic [DATA_W-1:0]    r_shift, w_shift_d;
  logic [DIV_W-1:0]     r_div, w_div_d;
  logic [DIV_W-1:0]     r_baud_cnt, w_baud_cnt_d;
  logic [BitCntW-1:0]   r_bit_cnt, w_bit_cnt_d;
  logic                 r_tx, w_tx_d;
  logic                 r_busy, w_busy_d;
  logic                 r_done, w_done_d;

  logic [DIV_W-1:0]     w_div_eff;
  logic [DATA_W-1:0]    w_shift_sr;
  logic                 w_bit_end;
  logic                 w_last_bit;

  // A divisor of 0 behaves like 1: one clock per bit.
  assign w_div_eff  = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign w_shift_sr = r_shift >> 1;
  // r_div is at least 1 whenever this is used outside idle.
  assign w_bit_end  = (r_baud_cnt == (r_div - DIV_W'(1)));
  assign w_last_bit = (r_bit_cnt == BitCntW'(DATA_W - 1));

  // Next-state and registered-output logic.
  always_comb begin
    w_state_d    = r_state;
    w_shift_d    = r_shift;
    w_div_d      = r_div;
    w_baud_cnt_d = r_baud_cnt;
    w_bit_cnt_d  = r_bit_cnt;
    w_tx_d       = r_tx;
    w_busy_d     = r_busy;
    w_done_d     = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_tx_d   = 1'b1;
        w_busy_d = 1'b0;
        if (tx_en && tx_start) begin
          w_state_d    = StStart;
          w_shift_d    = tx_data;
          w_div_d      = w_div_eff;
          w_baud_cnt_d = '0;
          w_bit_cnt_d  = '0;
          w_tx_d       = 1'b0;
          w_busy_d     = 1'b1;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_d    = StData;
          w_baud_cnt_d = '0;
          w_tx_d       = r_shift[0];
        end else begin
          w_baud_cnt_d = r_baud_cnt + DIV_W'(1);
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_baud_cnt_d = '0;
          if (w_last_bit) begin
            w_state_d = StStop;
            w_tx_d    = 1'b1;
          end else begin
            w_shift_d   = w_shift_sr;
            w_bit_cnt_d = r_bit_cnt + BitCntW'(1);
            w_tx_d      = w_shift_sr[0];
          end
        end else begin
          w_baud_cnt_d = r_baud_cnt + DIV_W'(1);
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_state_d    = StIdle;
          w_baud_cnt_d = '0;
          w_tx_d       = 1'b1;
          w_busy_d     = 1'b0;
          w_done_d     = 1'b1;
        end else begin
          w_baud_cnt_d = r_baud_cnt + DIV_W'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_tx_d    = 1'b1;
        w_busy_d  = 1'b0;
      end
    endcase

    // Dropping the enable mid-frame aborts without a done pulse.
    if ((r_state != StIdle) && !tx_en) begin
      w_state_d    = StIdle;
      w_baud_cnt_d = '0;
      w_bit_cnt_d  = '0;
      w_tx_d       = 1'b1;
      w_busy_d     = 1'b0;
      w_done_d     = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_div      <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_shift    <= w_shift_d;
      r_div      <= w_div_d;
      r_baud_cnt <= w_baud_cnt_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_tx       <= w_tx_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
    end
  end

  assign tx_o    = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed scenarios followed by random traffic, all
// checked cycle by cycle against a frame-timeline reference model.
module tb_uart_tx_engine;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
  localparam int FRAME_BITS = DATA_W + 2;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              tx_en;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [DIV_W-1:0]  baud_div;
  logic              tx_o;
  logic              tx_busy;
  logic              tx_done;

  uart_tx_engine #(
    .DATA_W(DATA_W),
    .DIV_W (DIV_W)
  ) u_dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .tx_en   (tx_en),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .baud_div(baud_div),
    .tx_o    (tx_o),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;

  // Reference model: a frame is a list of line levels, each held D cycles;
  // the expected line level is looked up by elapsed time since acceptance.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_t      = 0;
  int m_d      = 1;
  bit m_frame[FRAME_BITS];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n_cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (PRESET) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (m_active) begin
      if (!tx_en) begin
        m_active = 1'b0;
        m_done   = 1'b0;
      end else begin
        m_t++;
        if (m_t == FRAME_BITS * m_d) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_done = 1'b0;
        end
      end
    end else begin
      m_done = 1'b0;
      if (tx_en && tx_start) begin
        m_active = 1'b1;
        m_t      = 0;
        m_d      = (baud_div == 0) ? 1 : int'(baud_div);
        m_frame[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) m_frame[i+1] = tx_data[i];
        m_frame[FRAME_BITS-1] = 1'b1;
      end
    end
  endtask

  // One clock: inputs set earlier are sampled at the edge, outputs checked 1ns later.
  task automatic step();
    logic exp_tx;
    @(posedge PCLK);
    n_cyc++;
    model_edge();
    #1;
    exp_tx = m_active ? m_frame[m_t / m_d] : 1'b1;
    check_eq("tx_o", 32'(tx_o), 32'(exp_tx));
    check_eq("tx_busy", 32'(tx_busy), 32'(m_active));
    check_eq("tx_done", 32'(tx_done), 32'(m_done));
  endtask

  task automatic send(input logic [DATA_W-1:0] data, input logic [DIV_W-1:0] div);
    tx_data  = data;
    baud_div = div;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  int done_seen;

  initial begin
    // Reset with start requested: outputs must stay idle.
    PRESET   = 1'b1;
    tx_en    = 1'b1;
    tx_start = 1'b1;
    tx_data  = '0;
    baud_div = '0;
    repeat (2) step();
    PRESET   = 1'b0;
    tx_start = 1'b0;
    step();

    // Frame 8'hA5 at 4 clocks per bit; done counted to land exactly at cycle 40.
    send(8'hA5, 16'd4);
    done_seen = 0;
    for (int i = 1; i <= 45; i++) begin
      step();
      if (tx_done) done_seen = i;
    end
    check_eq("done_at_40", 32'(done_seen), 32'd40);

    // Divisor 0 means one clock per bit.
    send(8'h01, 16'd0);
    repeat (12) step();

    // Start held high: back-to-back frames, data change mid-frame ignored.
    tx_data  = 8'hFF;
    baud_div = 16'd2;
    tx_start = 1'b1;
    step();
    tx_data  = 8'h00;
    repeat (45) step();
    tx_start = 1'b0;
    repeat (25) step();

    // Abort during data bit 3.
    send(8'h3C, 16'd3);
    repeat (13) step();
    tx_en = 1'b0;
    step();
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    tx_en    = 1'b1;
    repeat (3) step();
    send(8'h96, 16'd1);
    repeat (14) step();

    // Reset during the stop bit.
    send(8'h5A, 16'd2);
    repeat (18) step();
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    repeat (30) step();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      PRESET   = ($urandom_range(0, 299) == 0);
      tx_en    = ($urandom_range(0, 79) != 0);
      tx_start = ($urandom_range(0, 3) == 0);
      tx_data  = DATA_W'($urandom);
      baud_div = DIV_W'($urandom_range(0, 5));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
